// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: latches two operands on start and adds them LSB-first,
// one bit per cycle, through a single full-add cell. Define SERIAL_SUB_EN to add the sub input.
module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] count;

  logic             half_s;
  logic             s;
  logic             c_next;
  logic             sub_sel;
  logic             last_bit;

  // Two half adders plus the carry OR.
  always_comb begin
    half_s   = a_sr[0] ^ b_sr[0];
    s        = half_s ^ carry;
    c_next   = (a_sr[0] & b_sr[0]) | (carry & half_s);
    last_bit = (count == CNT_W'(WIDTH - 1));
  end

`ifdef SERIAL_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      carry <= 1'b0;
      count <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B at load and preset the carry.
            a_sr  <= a;
            b_sr  <= sub_sel ? ~b : b;
            carry <= sub_sel;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          sum   <= {s, sum[WIDTH-1:1]};
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= c_next;
          count <= count + CNT_W'(1);
          if (last_bit) begin
            cout  <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8): vector table plus hand-written
// sequences for start-while-busy, mid-operation reset and back-to-back starts.
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             sub_in = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef SERIAL_SUB_EN
    .sub   (sub_in),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Starts one operation from a negedge in IDLE and returns at the negedge after done.
  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic vsub, input logic [WIDTH-1:0] es, input logic ec);
    int lat;
    start = 1'b1; a = va; b = vb; sub_in = vsub;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("done_latency", lat, WIDTH);
    chk("sum", {24'd0, sum}, {24'd0, es});
    chk("cout", {31'd0, cout}, {31'd0, ec});
    $display("op a=%02h b=%02h sub=%0d -> sum=%02h cout=%0d latency=%0d", va, vb, vsub, sum, cout, lat);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_cleared", {31'd0, busy}, 32'd0);
  endtask

  vec_t vecs[6];
`ifdef SERIAL_SUB_EN
  vec_t svecs[3];
`endif

  initial begin
    int n_done;
    int last_done_cyc;
    int cyc;
    logic [WIDTH-1:0] got_sum;
    logic             got_cout;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[5] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
`ifdef SERIAL_SUB_EN
    svecs[0] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1};
    svecs[1] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0};
    svecs[2] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0};
`endif

    // Reset state
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_sum", {24'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].exp_sum, vecs[i].exp_cout);

    // Result held in IDLE while start stays low
    a = 8'h11; b = 8'h22;
    repeat (3) @(negedge clk);
    chk("sum_hold", {24'd0, sum}, 32'h2C);
    chk("cout_hold", {31'd0, cout}, 32'd1);

    // start re-pulsed during ADD and during DONE is ignored
    start = 1'b1; a = 8'h10; b = 8'h20;
    @(posedge clk);
    n_done = 0; got_sum = '0; got_cout = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        got_sum = sum;
        got_cout = cout;
      end
      start = (i == 3) || done;
      a = 8'hAA; b = 8'h55;
      @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;
    $display("ignore-start: done pulses=%0d sum=%02h cout=%0d", n_done, got_sum, got_cout);
    chk("ignore_done_count", n_done, 1);
    chk("ignore_sum", {24'd0, got_sum}, 32'h30);
    chk("ignore_cout", {31'd0, got_cout}, 32'd0);
    chk("ignore_no_restart", {31'd0, busy}, 32'd0);

    // Reset mid-operation aborts with no done pulse
    start = 1'b1; a = 8'h7F; b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    $display("mid-reset: busy=%0d sum=%02h cout=%0d done=%0d", busy, sum, cout, done);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

    // start held high: a result every WIDTH+2 cycles
    start = 1'b1; a = 8'h01; b = 8'h01;
    n_done = 0; last_done_cyc = 0;
    for (cyc = 1; cyc <= 36; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        $display("b2b: done at cycle %0d sum=%02h cout=%0d", cyc, sum, cout);
        chk("b2b_sum", {24'd0, sum}, 32'h02);
        if (n_done > 0) chk("b2b_spacing", cyc - last_done_cyc, WIDTH + 2);
        else chk("b2b_first", cyc, WIDTH + 1);
        n_done++;
        last_done_cyc = cyc;
      end
    end
    start = 1'b0;
    chk("b2b_count", n_done, 3);
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);

`ifdef SERIAL_SUB_EN
    for (int i = 0; i < 3; i++)
      run_op(svecs[i].a, svecs[i].b, svecs[i].sub, svecs[i].exp_sum, svecs[i].exp_cout);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial adder sequencer. Latches two WIDTH-bit operands on a start request, then steps one shared 1-bit add cell (two half adders plus carry OR, with a carry flop) LSB-first over WIDTH cycles. It presents the full sum and carry-out with a one-cycle done pulse. Sits beside the combinational adder blocks as the low-area, multi-cycle alternative, driven by a start/busy/done handshake.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH)+1, bit counter width (derived, not overridden)

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous, active-high reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A; captured on the accepted start edge only
b      input   WIDTH  operand B; captured on the accepted start edge only
busy   output  1      high in ADD and DONE states
done   output  1      one-cycle pulse; sum/cout valid
sum    output  WIDTH  result register; held until next accepted start
cout   output  1      final carry; held with sum

Behaviour:
- Reset: one clk edge with rst=1 forces state=IDLE. It also clears busy=0, done=0, sum=0, cout=0, the carry flop, the counter and the operand shift registers.
- rst has priority over every other input.
- States: IDLE, ADD, DONE.
- IDLE: on a clk edge with start=1:
  - load a and b into the shift registers
  - carry flop <= 0, count <= 0, sum <= 0
  - next state = ADD
  - If start=0, stay in IDLE; sum and cout hold.
- ADD, on each edge:
  - s = a_sr[0]^b_sr[0]^c
  - c_next = (a_sr[0]&b_sr[0]) | (c&(a_sr[0]^b_sr[0]))
  - sum <= {s, sum[WIDTH-1:1]}
  - a_sr and b_sr shift right by one; carry <= c_next; count <= count+1
  - On the edge where count==WIDTH-1: cout <= c_next, next state = DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: start accepted at edge k. Bits are processed at edges k+1 .. k+WIDTH. done is high in the cycle following edge k+WIDTH.
- Back-to-back throughput: one result every WIDTH+2 cycles.
- Outputs are registered; done is decoded from state==DONE.
- start while busy=1, including during DONE: ignored, with no effect on operands or result. The requester must re-assert start once busy=0.
- Intermediate sum bits are visible during ADD. sum is only defined as the result while done=1 and afterwards in IDLE.
- Wrap-around: the result is modulo 2^WIDTH; overflow is reported only through cout.
- Reset mid-operation: abort with no done pulse; all outputs return to reset values on that edge.

Optional Feature:
SERIAL_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured with the operands on the accepted start edge.
  - sub=1: B is inverted at load and the carry flop is preset to 1. The result is a-b modulo 2^WIDTH; cout=1 means no borrow (a>=b).
  - sub=0: behaviour identical to the add-only build.
- Undefined: no sub port, add only. Timing is identical in both builds.

Test Plan:
1. WIDTH=8, reset, then start with a=0x05, b=0x03 -> busy=1 the next cycle; done pulses exactly 8 cycles after the start edge; sum=0x08, cout=0; busy=0 one cycle later.
2. a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0x00, b=0x00 -> sum=0x00, cout=0, with cout cleared from the previous run.
3. start with a=0x10, b=0x20; re-pulse start at cycle 3 with a=0xAA, b=0x55, and again during DONE -> one done pulse only, sum=0x30, cout=0; no second operation starts.
4. start with a=0x7F, b=0x01; assert rst at cycle 4 after start -> next edge gives busy=0, sum=0x00, cout=0, no done pulse. A fresh start with a=0x7F, b=0x01 then gives sum=0x80, cout=0.
5. start held high continuously with a=0x01, b=0x01 -> repeated results of 0x02 with done pulses spaced WIDTH+2=10 cycles apart.
6. SERIAL_SUB_EN defined:
   - sub=1, a=0x05, b=0x03 -> sum=0x02, cout=1
   - sub=1, a=0x03, b=0x05 -> sum=0xFE, cout=0
   - sub=0, a=0x05, b=0x03 -> sum=0x08, cout=0
